// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FWFT FIFO controller: pointer and
// fill-count widths, and the occupancy encoding of the 2-entry output stage.
package ram_fifo_pkg;

   // Occupancy of the output skid stage (head + spare)
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   function automatic int ptrLen(input int addrLen);
      return addrLen + 1;
   endfunction

   // Fill count spans RAM depth plus one in-flight word plus two staged words
   function automatic int fillLen(input int addrLen);
      return addrLen + 2;
   endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output stage of the RAM FIFO. Words arriving from the RAM read
// port are parked in head (presented downstream) or spare. The upstream read
// issue logic guarantees a push never arrives when both slots stay occupied.
module fifo_skid2
   import ram_fifo_pkg::*;
#(
   parameter int CDataLen = 8
) (
   input  logic                AClk,
   input  logic                AResetN,
   input  logic                AClkEn,
   input  logic                AFlush,
   input  logic [CDataLen-1:0] APushData,
   input  logic                APushValid,
   input  logic                APopReady,
   output logic [CDataLen-1:0] AHeadData,
   output logic                AHeadValid,
   output logic [1:0]          AOcc
);

   occ_t                occ;
   occ_t                occNext;
   logic [CDataLen-1:0] head;
   logic [CDataLen-1:0] spare;
   logic [CDataLen-1:0] headNext;
   logic [CDataLen-1:0] spareNext;
   logic                pop;

   assign AHeadValid = (occ != OCC_EMPTY);
   assign AHeadData  = head;
   assign AOcc       = occ;
   assign pop        = AHeadValid & APopReady;

   // Next slot contents: a pop shifts spare into head, a push fills the first free slot after the pop
   always_comb begin
      occNext   = occ;
      headNext  = head;
      spareNext = spare;
      case ({pop, APushValid})
         2'b10: begin
            if (occ == OCC_TWO) begin
               headNext = spare;
               occNext  = OCC_ONE;
            end else begin
               occNext  = OCC_EMPTY;
            end
         end
         2'b01: begin
            if (occ == OCC_EMPTY) begin
               headNext = APushData;
               occNext  = OCC_ONE;
            end else begin
               spareNext = APushData;
               occNext   = OCC_TWO;
            end
         end
         2'b11: begin
            if (occ == OCC_TWO) begin
               headNext  = spare;
               spareNext = APushData;
            end else begin
               headNext  = APushData;
            end
         end
         default: ;
      endcase
   end

   // Occupancy register; flush empties the stage without touching the data slots
   always_ff @(posedge AClk or negedge AResetN) begin
      if (!AResetN) begin
         occ <= OCC_EMPTY;
      end else if (AClkEn) begin
         occ <= AFlush ? OCC_EMPTY : occNext;
      end
   end

   // Data slots need no reset: they are only observed while occupancy says they hold a word
   always_ff @(posedge AClk) begin
      if (AClkEn) begin
         head  <= headNext;
         spare <= spareNext;
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for a dual-port block RAM (port A
// writes, port B reads). Hides the RAM's one-clock read latency behind a
// 2-entry output stage so both sides can sustain one word per clock.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int CAddrLen = 11,
   parameter int CDataLen = 8
) (
   input  logic                  AClk,
   input  logic                  AResetN,
   input  logic                  AClkEn,
   input  logic                  AFlush,
   input  logic [CDataLen-1:0]   AWrData,
   input  logic                  AWrValid,
   output logic                  AWrReady,
   output logic [CDataLen-1:0]   AOutData,
   output logic                  AOutValid,
   input  logic                  AOutReady,
   output logic [CAddrLen+1:0]   AFill,
   output logic [CAddrLen-1:0]   AMemAddrA,
   output logic [CDataLen-1:0]   AMemMosiA,
   output logic                  AMemWrEnA,
   output logic [CAddrLen-1:0]   AMemAddrB,
   output logic                  AMemRdEnB,
   input  logic [CDataLen-1:0]   AMemMisoB
);

   localparam int CPtrLen  = ptrLen(CAddrLen);
   localparam int CFillLen = fillLen(CAddrLen);

   logic [CPtrLen-1:0]  wrPtr;
   logic [CPtrLen-1:0]  rdPtr;
   logic [CPtrLen-1:0]  memCnt;
   logic                rdPend;
   logic                ramEmpty;
   logic                ramFull;
   logic                wrAcc;
   logic                popNow;
   logic                rdIssue;
   logic [2:0]          stageLoad;
   logic [1:0]          occ;
   logic                headValid;
   logic [CDataLen-1:0] headData;

   assign memCnt   = wrPtr - rdPtr;
   assign ramEmpty = (wrPtr == rdPtr);
   assign ramFull  = (wrPtr[CAddrLen] != rdPtr[CAddrLen]) &&
                     (wrPtr[CAddrLen-1:0] == rdPtr[CAddrLen-1:0]);

   assign AWrReady = ~AFlush & ~ramFull;
   assign wrAcc    = AWrValid & AWrReady;
   assign popNow   = headValid & AOutReady;

   // Slots the stage will need once this clock's pop and the in-flight word settle;
   // a read is only issued when a slot is guaranteed free on arrival
   assign stageLoad = {1'b0, occ} - {2'b00, popNow} + {2'b00, rdPend};
   assign rdIssue   = ~AFlush & ~ramEmpty & (stageLoad < 3'd2);

   assign AMemAddrA = wrPtr[CAddrLen-1:0];
   assign AMemMosiA = AWrData;
   assign AMemWrEnA = wrAcc;
   assign AMemAddrB = rdPtr[CAddrLen-1:0];
   assign AMemRdEnB = rdIssue;

   assign AOutValid = headValid;
   assign AOutData  = headValid ? headData : '0;
   assign AFill     = {1'b0, memCnt}
                    + {{(CFillLen-1){1'b0}}, rdPend}
                    + {{(CFillLen-2){1'b0}}, occ};

   // Pointers and read-pending flag; flush drops everything including a word still in the RAM pipe
   always_ff @(posedge AClk or negedge AResetN) begin
      if (!AResetN) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         rdPend <= 1'b0;
      end else if (AClkEn) begin
         if (AFlush) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            rdPend <= 1'b0;
         end else begin
            if (wrAcc) begin
               wrPtr <= wrPtr + CPtrLen'(1);
            end
            if (rdIssue) begin
               rdPtr <= rdPtr + CPtrLen'(1);
            end
            rdPend <= rdIssue;
         end
      end
   end

   fifo_skid2 #(
      .CDataLen (CDataLen)
   ) uSkid (
      .AClk       (AClk),
      .AResetN    (AResetN),
      .AClkEn     (AClkEn),
      .AFlush     (AFlush),
      .APushData  (AMemMisoB),
      .APushValid (rdPend),
      .APopReady  (AOutReady),
      .AHeadData  (headData),
      .AHeadValid (headValid),
      .AOcc       (occ)
   );

endmodule
